bcd_tick_counter: RTL and testbench
===================================

# bcd_tick_counter

Two-digit BCD counter, 00–99, that feeds the seven-segment encoders on the Go Board. A prescaler turns the 25 MHz clock into a periodic count event. Each count event advances the count by one, up or down. The block outputs one registered 4-bit BCD digit per display (ones, tens), plus single-cycle status pulses, so the display stage only decodes digits.

## Interface
Parameters:
- TICK_CYCLES, 12_500_000, clock cycles between prescaler count events (0.5 s at 25 MHz); must be ≥ 2
- DOWN_WRAP_VALUE, 99, value loaded when counting down from 00; must be valid BCD, ≤ 99

Ports (clock and reset first):
- i_Clk  in  1  system clock, 25 MHz
- i_Rst  in  1  reset, synchronous, active-high
- i_Run  in  1  level; 1 = prescaler advances, 0 = prescaler holds its value
- i_Step  in  1  one-cycle pulse; manual count event, independent of i_Run
- i_Down  in  1  level; 0 = count up, 1 = count down; sampled on each count event
- i_Clear  in  1  level; synchronous clear of the count and the prescaler
- o_Ones  out  4  ones digit, BCD 0–9, registered
- o_Tens  out  4  tens digit, BCD 0–9, registered
- o_Tick  out  1  high for exactly one cycle when a new count value first appears
- o_Wrap  out  1  high for exactly one cycle when the count wraps (99→00 up, 00→DOWN_WRAP_VALUE down)

## Operation
- Reset (i_Rst=1 at a rising edge): o_Ones=0, o_Tens=0, o_Tick=0, o_Wrap=0, prescaler=0.
- Prescaler: counter 0..TICK_CYCLES-1, width $clog2(TICK_CYCLES).
  - While i_Run=1 it increments every cycle.
  - At TICK_CYCLES-1 it returns to 0 and raises an internal event.
  - While i_Run=0 it holds its value. No event is raised and it does not clear.
- Count event = prescaler event OR i_Step. If both occur in the same cycle, the count advances by one only.
- Up event:
  - Ones 0–8 → +1.
  - Ones 9 → ones=0 and tens +1.
  - Count 99 → 00, with o_Wrap.
- Down event:
  - Ones 1–9 → −1.
  - Ones 0 → ones=9 and tens −1.
  - Count 00 → DOWN_WRAP_VALUE, with o_Wrap.
- Digits never leave the range 0–9. Non-BCD states are unreachable.
- Priority, highest first: i_Rst, i_Clear, count event.
  - i_Clear gives the same register values as reset.
  - i_Clear suppresses o_Tick and o_Wrap, even when it coincides with an event.
- A change of i_Down takes effect at the next count event. It does not reset the prescaler.
- i_Step does not disturb the prescaler phase.

## Timing
- Latency: an event sampled at edge n produces the new digits, o_Tick=1 and (if wrapping) o_Wrap=1, all visible after edge n. Flags drop after edge n+1 unless another event occurs.
- With i_Run=1 continuously from reset release, the first advance is registered at the TICK_CYCLES-th edge. After that, one advance every TICK_CYCLES edges exactly.
- When i_Run goes low then high again, counting resumes from the held prescaler value. The remaining cycles before the next event are preserved.
- Back-to-back i_Step pulses (every cycle) advance the count once per cycle, with o_Tick high on each.
- o_Tick and o_Wrap are never high for two consecutive cycles from a single event.
- If reset or i_Clear is applied mid-count, everything is back at 00 / prescaler 0 after that edge. The next prescaler event comes TICK_CYCLES edges after release.

## Structure
- Shared package seg_pkg holds:
  - constant CLK_HZ=25_000_000
  - constant HALF_SECOND_CYCLES=12_500_000
  - constant BCD_W=4
  - constant BCD_MAX=9
  - typedef bcd_t (logic [3:0]); the seven-segment encoder imports the same type
- Sub-module bcd_digit: one decade counter.
  - Inputs: clk, rst, clr, en, down.
  - Outputs: digit, carry/borrow.
  - Instantiated twice. The ones-digit carry/borrow drives the tens-digit enable.
  - The top level handles the DOWN_WRAP_VALUE load and o_Wrap.
- Prescaler lives in the top level.

## Test plan
Run with TICK_CYCLES=50, DOWN_WRAP_VALUE=99 unless noted.
- Reset, then i_Run=1 and i_Down=0 → 01 appears after exactly 50 edges, then +1 every 50 edges; o_Tick pulses once per advance.
- Run up from 00 to 99, then one more event → 00, with o_Tick and o_Wrap both high for one cycle. At 09→10, ones=0 and tens=1 in the same cycle.
- i_Down=1 at 00, one i_Step → 99 with o_Wrap. Continue down 10→09.
- Repeat with DOWN_WRAP_VALUE=59: 00 → 59.
- i_Run=1, pulse i_Step on the same edge as a prescaler event → count advances by one only. i_Run=0 for 30 cycles mid-period → next advance is delayed by exactly 30 cycles.
- At count 42, raise i_Clear on the same edge as a prescaler event → 00, o_Tick=0, o_Wrap=0. After release, the next advance comes after 50 edges.
- Hold i_Rst for 3 cycles mid-count → all outputs 0. Check that o_Ones and o_Tens are always ≤ 9 throughout every scenario.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared display-path definitions: clock rate, BCD digit type and limits.
// The seven-segment encoder imports the same bcd_t so digits pass through unchanged.
package seg_pkg;

  localparam int CLK_HZ             = 25_000_000;
  localparam int HALF_SECOND_CYCLES = 12_500_000;
  localparam int BCD_W              = 4;
  localparam int BCD_MAX            = 9;

  typedef logic [BCD_W-1:0] bcd_t;

endpackage

// File: rtl/bcd_digit.sv
// One decade counter (0-9) with up/down stepping, parallel load and a
// combinational carry/borrow that fires when an enabled step rolls the digit over.
module bcd_digit
  import seg_pkg::*;
(
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Clr,
  input  logic i_En,
  input  logic i_Down,
  input  logic i_Load,
  input  bcd_t i_Load_Val,
  output bcd_t o_Digit,
  output logic o_Carry
);

  bcd_t r_digit;
  logic w_at_limit;

  assign w_at_limit = i_Down ? (r_digit == '0) : (r_digit == bcd_t'(BCD_MAX));
  assign o_Carry    = i_En & w_at_limit;
  assign o_Digit    = r_digit;

  // Load wins over stepping so the parent can override the natural roll-over value.
  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_Clr) begin
      r_digit <= '0;
    end else if (i_Load) begin
      r_digit <= i_Load_Val;
    end else if (i_En) begin
      if (w_at_limit) begin
        r_digit <= i_Down ? bcd_t'(BCD_MAX) : '0;
      end else if (i_Down) begin
        r_digit <= r_digit - bcd_t'(1);
      end else begin
        r_digit <= r_digit + bcd_t'(1);
      end
    end
  end

endmodule

// File: rtl/bcd_tick_counter.sv
// Two-digit BCD up/down counter (00-99) advanced by a free-running prescaler
// or a manual step pulse; emits registered digits plus one-cycle tick/wrap flags.
module bcd_tick_counter
  import seg_pkg::*;
#(
  parameter int TICK_CYCLES     = HALF_SECOND_CYCLES,
  parameter int DOWN_WRAP_VALUE = 99
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Run,
  input  logic i_Step,
  input  logic i_Down,
  input  logic i_Clear,
  output bcd_t o_Ones,
  output bcd_t o_Tens,
  output logic o_Tick,
  output logic o_Wrap
);

  localparam int               PRE_W     = $clog2(TICK_CYCLES);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_CYCLES - 1);
  localparam bcd_t             WRAP_ONES = bcd_t'(DOWN_WRAP_VALUE % 10);
  localparam bcd_t             WRAP_TENS = bcd_t'(DOWN_WRAP_VALUE / 10);

  logic [PRE_W-1:0] r_pre;
  logic             r_tick;
  logic             r_wrap;
  logic             w_pre_event;
  logic             w_count_event;
  logic             w_count_en;
  logic             w_ones_carry;
  logic             w_tens_carry;
  logic             w_load;

  assign w_pre_event   = i_Run && (r_pre == PRE_LAST);
  assign w_count_event = w_pre_event | i_Step;
  assign w_count_en    = w_count_event & ~i_Clear;

  // A tens carry/borrow only happens when both digits roll over, i.e. 99->00 or 00->wrap.
  assign w_load = w_tens_carry & i_Down;

  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_Clear) begin
      r_pre <= '0;
    end else if (i_Run) begin
      r_pre <= w_pre_event ? '0 : r_pre + 1'b1;
    end
  end

  bcd_digit u_ones (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Clr      (i_Clear),
    .i_En       (w_count_en),
    .i_Down     (i_Down),
    .i_Load     (w_load),
    .i_Load_Val (WRAP_ONES),
    .o_Digit    (o_Ones),
    .o_Carry    (w_ones_carry)
  );

  bcd_digit u_tens (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Clr      (i_Clear),
    .i_En       (w_ones_carry),
    .i_Down     (i_Down),
    .i_Load     (w_load),
    .i_Load_Val (WRAP_TENS),
    .o_Digit    (o_Tens),
    .o_Carry    (w_tens_carry)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_Clear) begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_tick <= w_count_event;
      r_wrap <= w_tens_carry;
    end
  end

  assign o_Tick = r_tick;
  assign o_Wrap = r_wrap;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Bench for bcd_tick_counter: two instances (down-wrap 99 and 59) driven in lockstep
// against an integer reference model whose expectations are queued per clock.
module tb_bcd_tick_counter;

  localparam int TC = 50;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       i_Run = 1'b0;
  logic       i_Step = 1'b0;
  logic       i_Down = 1'b0;
  logic       i_Clear = 1'b0;
  logic [3:0] o_Ones, o_Tens, b_Ones, b_Tens;
  logic       o_Tick, o_Wrap, b_Tick, b_Wrap;

  bcd_tick_counter #(.TICK_CYCLES(TC), .DOWN_WRAP_VALUE(99)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Run(i_Run), .i_Step(i_Step), .i_Down(i_Down),
    .i_Clear(i_Clear), .o_Ones(o_Ones), .o_Tens(o_Tens), .o_Tick(o_Tick), .o_Wrap(o_Wrap)
  );

  bcd_tick_counter #(.TICK_CYCLES(TC), .DOWN_WRAP_VALUE(59)) dut59 (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Run(i_Run), .i_Step(i_Step), .i_Down(i_Down),
    .i_Clear(i_Clear), .o_Ones(b_Ones), .o_Tens(b_Tens), .o_Tick(b_Tick), .o_Wrap(b_Wrap)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    int c;
    int c59;
    bit t;
    bit w;
    bit w59;
  } exp_t;

  exp_t sb[$];
  int   m_c = 0, m_c59 = 0, m_pre = 0;
  int   n_err = 0, n_chk = 0;
  bit   armed = 1'b0;

  function automatic int nxt(int c, int wrapv, bit dn);
    if (dn) return (c == 0) ? wrapv : c - 1;
    return (c == 99) ? 0 : c + 1;
  endfunction

  function automatic logic [19:0] dut_vec();
    return {o_Tens, o_Ones, o_Tick, o_Wrap, b_Tens, b_Ones, b_Tick, b_Wrap};
  endfunction

  function automatic logic [19:0] exp_vec(exp_t e);
    return {4'(e.c / 10), 4'(e.c % 10), e.t, e.w, 4'(e.c59 / 10), 4'(e.c59 % 10), e.t, e.w59};
  endfunction

  // Advance the model with the inputs currently driven, queue the expectation, clock once.
  task automatic tick1();
    exp_t e;
    bit   ev;
    e.t = 1'b0; e.w = 1'b0; e.w59 = 1'b0;
    if (i_Rst || i_Clear) begin
      m_c = 0; m_c59 = 0; m_pre = 0;
    end else begin
      ev = 1'b0;
      if (i_Run) begin
        if (m_pre == TC - 1) begin m_pre = 0; ev = 1'b1; end
        else m_pre++;
      end
      ev  = ev | i_Step;
      e.t = ev;
      if (ev) begin
        e.w   = i_Down ? (m_c == 0) : (m_c == 99);
        e.w59 = i_Down ? (m_c59 == 0) : (m_c59 == 99);
        m_c   = nxt(m_c, 99, i_Down);
        m_c59 = nxt(m_c59, 59, i_Down);
      end
    end
    e.c = m_c; e.c59 = m_c59;
    sb.push_back(e);
    @(posedge i_Clk);
    #1;
  endtask

  always @(negedge i_Clk) begin
    if (armed) begin
      n_chk++;
      if (o_Ones > 4'd9 || o_Tens > 4'd9 || b_Ones > 4'd9 || b_Tens > 4'd9) begin
        n_err++;
        $display("FAIL digit_range: got %0d%0d / %0d%0d, each digit must be <= 9",
                 o_Tens, o_Ones, b_Tens, b_Ones);
      end
    end
  end

  task automatic test_reset();
    exp_t e;
    i_Rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick1();
      e = sb.pop_front(); n_chk++;
      if (dut_vec() !== exp_vec(e)) begin
        n_err++; $display("FAIL reset cyc %0d: got %h want %h", i, dut_vec(), exp_vec(e));
      end
    end
    armed = 1'b1;
    n_chk++;
    if ({o_Tens, o_Ones, o_Tick, o_Wrap} !== 10'd0) begin
      n_err++; $display("FAIL reset_state: got %h want 000", {o_Tens, o_Ones, o_Tick, o_Wrap});
    end
    i_Rst = 1'b0;
  endtask

  task automatic test_run_up();
    exp_t e;
    i_Run = 1'b1; i_Down = 1'b0;
    for (int i = 1; i <= 3 * TC; i++) begin
      tick1();
      e = sb.pop_front(); n_chk++;
      if (dut_vec() !== exp_vec(e)) begin
        n_err++; $display("FAIL run_up edge %0d: got %h want %h", i, dut_vec(), exp_vec(e));
      end
      if (i == TC - 1 || i == TC || i == 2 * TC) begin
        n_chk++;
        if ({o_Tens, o_Ones, o_Tick} !== {4'd0, 4'(i / TC), (i % TC) == 0}) begin
          n_err++; $display("FAIL first_advance edge %0d: got %0d%0d tick=%b", i, o_Tens, o_Ones, o_Tick);
        end
      end
    end
  endtask

  task automatic test_wrap_up();
    exp_t e;
    i_Run = 1'b0; i_Step = 1'b1;
    for (int i = 0; i < 200 && m_c != 99; i++) begin
      tick1();
      e = sb.pop_front(); n_chk++;
      if (dut_vec() !== exp_vec(e)) begin
        n_err++; $display("FAIL step_up step %0d: got %h want %h", i, dut_vec(), exp_vec(e));
      end
    end
    tick1();
    e = sb.pop_front(); n_chk++;
    if ({o_Tens, o_Ones, o_Tick, o_Wrap} !== {8'h00, 2'b11}) begin
      n_err++; $display("FAIL wrap_up: got %0d%0d tick=%b wrap=%b want 00 1 1", o_Tens, o_Ones, o_Tick, o_Wrap);
    end
    i_Step = 1'b0;
    tick1();
    e = sb.pop_front(); n_chk++;
    if (dut_vec() !== exp_vec(e)) begin
      n_err++; $display("FAIL wrap_up_drop: got %h want %h", dut_vec(), exp_vec(e));
    end
  endtask

  task automatic test_down();
    exp_t e;
    i_Down = 1'b1; i_Step = 1'b1;
    tick1();
    e = sb.pop_front(); n_chk++;
    if ({o_Tens, o_Ones, o_Wrap, b_Tens, b_Ones, b_Wrap} !== {8'h99, 1'b1, 8'h59, 1'b1}) begin
      n_err++; $display("FAIL down_wrap: got %0d%0d w=%b / %0d%0d w=%b want 99 1 / 59 1",
                        o_Tens, o_Ones, o_Wrap, b_Tens, b_Ones, b_Wrap);
    end
    for (int i = 0; i < 200 && m_c != 9; i++) begin
      tick1();
      e = sb.pop_front(); n_chk++;
      if (dut_vec() !== exp_vec(e)) begin
        n_err++; $display("FAIL step_down step %0d: got %h want %h", i, dut_vec(), exp_vec(e));
      end
    end
    n_chk++;
    if ({o_Tens, o_Ones} !== 8'h09) begin
      n_err++; $display("FAIL down_borrow: got %0d%0d want 09", o_Tens, o_Ones);
    end
    i_Step = 1'b0; i_Down = 1'b0;
  endtask

  task automatic test_step_and_pause();
    exp_t e;
    i_Clear = 1'b1; tick1(); void'(sb.pop_front()); i_Clear = 1'b0;
    i_Run = 1'b1;
    for (int i = 1; i <= TC + 20 + 30 + 30; i++) begin
      i_Step = (i == TC);
      i_Run  = !(i > TC + 20 && i <= TC + 50);
      tick1();
      e = sb.pop_front(); n_chk++;
      if (dut_vec() !== exp_vec(e)) begin
        n_err++; $display("FAIL step_pause edge %0d: got %h want %h", i, dut_vec(), exp_vec(e));
      end
      if (i == TC || i == TC + 79 || i == TC + 80) begin
        n_chk++;
        if ({o_Tens, o_Ones, o_Tick} !== {4'd0, (i == TC + 80) ? 4'd2 : 4'd1, i != TC + 79}) begin
          n_err++; $display("FAIL step_pause_pt edge %0d: got %0d%0d tick=%b", i, o_Tens, o_Ones, o_Tick);
        end
      end
    end
    i_Step = 1'b0;
  endtask

  task automatic test_clear();
    exp_t e;
    i_Clear = 1'b1; tick1(); void'(sb.pop_front()); i_Clear = 1'b0;
    i_Run = 1'b0; i_Step = 1'b1;
    for (int i = 0; i < 42; i++) begin tick1(); void'(sb.pop_front()); end
    i_Step = 1'b0; i_Run = 1'b1;
    for (int i = 1; i <= TC + TC; i++) begin
      i_Clear = (i == TC);
      tick1();
      e = sb.pop_front(); n_chk++;
      if (dut_vec() !== exp_vec(e)) begin
        n_err++; $display("FAIL clear edge %0d: got %h want %h", i, dut_vec(), exp_vec(e));
      end
      if (i == TC - 1 || i == TC || i == 2 * TC) begin
        n_chk++;
        if ({o_Tens, o_Ones, o_Tick, o_Wrap} !==
            {(i == TC - 1) ? 8'h42 : (i == TC) ? 8'h00 : 8'h01, i == 2 * TC, 1'b0}) begin
          n_err++; $display("FAIL clear_pt edge %0d: got %0d%0d tick=%b wrap=%b", i, o_Tens, o_Ones, o_Tick, o_Wrap);
        end
      end
    end
    i_Clear = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    i_Run = 1'b0; i_Step = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick1();
      e = sb.pop_front(); n_chk++;
      if (dut_vec() !== exp_vec(e) || o_Tick !== 1'b1) begin
        n_err++; $display("FAIL back_to_back %0d: got %h want %h", i, dut_vec(), exp_vec(e));
      end
    end
    i_Step = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    i_Run = 1'b1;
    for (int i = 1; i <= 20 + 3 + TC; i++) begin
      i_Rst = (i > 20 && i <= 23);
      tick1();
      e = sb.pop_front(); n_chk++;
      if (dut_vec() !== exp_vec(e)) begin
        n_err++; $display("FAIL reset_mid edge %0d: got %h want %h", i, dut_vec(), exp_vec(e));
      end
      if (i > 20 && i <= 23) begin
        n_chk++;
        if ({o_Tens, o_Ones, o_Tick, o_Wrap, b_Tens, b_Ones} !== 18'd0) begin
          n_err++; $display("FAIL reset_mid_zero edge %0d: got %0d%0d / %0d%0d", i, o_Tens, o_Ones, b_Tens, b_Ones);
        end
      end
    end
    i_Rst = 1'b0;
    n_chk++;
    if ({o_Tens, o_Ones, o_Tick} !== {8'h01, 1'b1}) begin
      n_err++; $display("FAIL reset_release: got %0d%0d tick=%b want 01 1", o_Tens, o_Ones, o_Tick);
    end
  endtask

  initial begin
    test_reset();
    test_run_up();
    test_wrap_up();
    test_down();
    test_step_and_pause();
    test_clear();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
